// File: rtl/crg_seq_ctrl.sv
// Sequencer between the UART command controller and the CRG core: holds the host seed/config words,
// launches the core iter times per run, XOR-accumulates the results and guards each launch with a watchdog.
module crg_seq_ctrl #(
    parameter int LEN_DIN  = 256,
    parameter int LEN_DOUT = 768,
    parameter int N_SEED   = 2,
    parameter int WDOG_CYC = 1048576
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       extin_en,
    input  logic [7:0]                 addr_extin,
    input  logic [LEN_DIN-1:0]         extin_data,
    input  logic                       run,
    output logic                       core_start,
    output logic [N_SEED*LEN_DIN-1:0]  core_seed,
    input  logic                       core_done,
    input  logic [LEN_DOUT-1:0]        core_result,
    output logic [LEN_DOUT-1:0]        result,
    output logic [7:0]                 status
);

    localparam int                  WDOG_W    = $clog2(WDOG_CYC);
    localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
    localparam logic [7:0]          ADDR_CFG  = 8'h10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]                state_q,      state_d;
    logic [N_SEED*LEN_DIN-1:0] seed_q,       seed_d;
    logic [15:0]               iter_q,       iter_d;
    logic [15:0]               it_cnt_q,     it_cnt_d;
    logic [WDOG_W-1:0]         wdog_q,       wdog_d;
    logic [LEN_DOUT-1:0]       result_q,     result_d;
    logic                      core_start_q, core_start_d;
    logic                      busy_q,       busy_d;
    logic                      done_q,       done_d;
    logic                      timeout_q,    timeout_d;
    logic                      wr_err_q,     wr_err_d;
    logic                      busy_now;

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        iter_d    = iter_q;
        it_cnt_d  = it_cnt_q;
        wdog_d    = wdog_q;
        result_d  = result_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        wr_err_d  = wr_err_q;
        busy_now  = (state_q == S_START) || (state_q == S_WAIT);

        // Host writes only land while no run is in flight, so seed and iter stay stable during a run.
        if (extin_en) begin
            if (busy_now) begin
                wr_err_d = 1'b1;
            end else begin
                for (int i = 0; i < N_SEED; i++) begin
                    if (addr_extin == 8'(i)) begin
                        seed_d[i*LEN_DIN +: LEN_DIN] = extin_data;
                    end
                end
                if (addr_extin == ADDR_CFG) begin
                    iter_d = (extin_data[15:0] == 16'd0) ? 16'd1 : extin_data[15:0];
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (run) begin
                    result_d  = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    wr_err_d  = 1'b0;
                    it_cnt_d  = 16'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the same cycle as watchdog expiry is still accepted.
                if (core_done) begin
                    result_d = result_q ^ core_result;
                    if (it_cnt_q == iter_q - 16'd1) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        it_cnt_d = it_cnt_q + 16'd1;
                        state_d  = S_START;
                    end
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    if (wdog_d == WDOG_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_start_d = (state_d == S_START);
        busy_d       = (state_d == S_START) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            seed_q       <= '0;
            iter_q       <= 16'd1;
            it_cnt_q     <= 16'd0;
            wdog_q       <= '0;
            result_q     <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            iter_q       <= iter_d;
            it_cnt_q     <= it_cnt_d;
            wdog_q       <= wdog_d;
            result_q     <= result_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign core_start = core_start_q;
    assign core_seed  = seed_q;
    assign result     = result_q;
    assign status     = {4'b0000, wr_err_q, timeout_q, done_q, busy_q};

endmodule
